// File: rtl/bit_ctrl_seq_monitor_if.sv
// rtl/bit_ctrl_seq_monitor_if.sv - observe-side bus for the bit_ctrl sequence monitor
//
// Groups the monitored pattern, the error clear and all monitor results.
//   master : drives pat_in / clr_err, observes results (bench or host logic)
//   slave  : the monitor itself
// Ports (slave view):
//   pat_in   in  8      drive pattern, asynchronous to the monitor clock
//   clr_err  in  1      one-cycle clear of the sticky error
//   step     out 3      last valid decoded step index 0..5
//   step_vld out 1      current pattern decodes to a valid step
//   dir      out 1      1 = forward, 0 = reverse
//   locked   out 1      same-direction run has reached LOCK_COUNT
//   err      out 1      sticky error flag
//   err_code out 2      first error since clear: 01 invalid, 10 skip
//   step_cnt out CNT_W  accepted transitions, wrapping
interface bit_ctrl_seq_monitor_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       pat_in;
    logic             clr_err;
    logic [2:0]       step;
    logic             step_vld;
    logic             dir;
    logic             locked;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        output pat_in, clr_err,
        input  step, step_vld, dir, locked, err, err_code, step_cnt
    );

    modport slave (
        input  pat_in, clr_err,
        output step, step_vld, dir, locked, err, err_code, step_cnt
    );
endinterface

// File: rtl/bit_ctrl_seq_monitor.sv
// rtl/bit_ctrl_seq_monitor.sv - six-step two-hot pattern decoder, direction/lock tracker and step counter
//
// Synchronizes pat_in through two flops, decodes the six-step two-hot pattern
// to an index and classifies each change as forward, reverse, skip or invalid.
// Optional macro GLITCH_FILTER_EN: a decoded value is only accepted after it
// has been seen on the synchronizer output for two consecutive cycles.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   mon    slave modport of bit_ctrl_seq_monitor_if (pattern in, results out)
module bit_ctrl_seq_monitor #(
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bit_ctrl_seq_monitor_if.slave    mon
);
    localparam logic [3:0] LOCK_TH = 4'(LOCK_COUNT);

    // {valid, index}; invalid patterns decode to 4'b0000
    function automatic logic [3:0] decode(input logic [7:0] p);
        case (p)
            8'h90:   decode = 4'b1000;
            8'h18:   decode = 4'b1001;
            8'h48:   decode = 4'b1010;
            8'h60:   decode = 4'b1011;
            8'h24:   decode = 4'b1100;
            8'h84:   decode = 4'b1101;
            default: decode = 4'b0000;
        endcase
    endfunction

    logic [7:0]       s1_q, s2_q;
    logic             prev_vld_q, prev_vld_d;
    logic [2:0]       step_q, step_d;
    logic             vld_q, vld_d;
    logic             dir_q, dir_d;
    logic [3:0]       run_q, run_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] dec;
    logic       accept;
    logic [2:0] idx, nxt_fwd, nxt_rev;
    logic [1:0] raise;
    logic       fwd;

`ifdef GLITCH_FILTER_EN
    logic [3:0] dec_prev_q;
    assign accept = (dec == dec_prev_q);
`else
    assign accept = 1'b1;
`endif

    assign dec     = decode(s2_q);
    assign idx     = dec[2:0];
    assign nxt_fwd = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
    assign nxt_rev = (step_q == 3'd0) ? 3'd5 : step_q - 3'd1;
    assign fwd     = (idx == nxt_fwd);

    always_comb begin
        prev_vld_d = prev_vld_q;
        step_d     = step_q;
        vld_d      = vld_q;
        dir_d      = dir_q;
        run_d      = run_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        code_d     = code_q;
        raise      = 2'b00;

        if (accept) begin
            if (dec[3]) begin
                vld_d = 1'b1;
                if (!prev_vld_q) begin
                    // acquire after reset or an invalid pattern
                    prev_vld_d = 1'b1;
                    step_d     = idx;
                    run_d      = 4'd0;
                end else if (idx == step_q) begin
                    // hold
                end else if (idx == nxt_fwd || idx == nxt_rev) begin
                    step_d = idx;
                    dir_d  = fwd;
                    cnt_d  = cnt_q + 1'b1;
                    if (dir_q == fwd)
                        run_d = (run_q == 4'hF) ? 4'hF : run_q + 4'd1;
                    else
                        run_d = 4'd1;
                end else begin
                    step_d = idx;
                    run_d  = 4'd0;
                    raise  = 2'b10;
                end
            end else begin
                vld_d      = 1'b0;
                prev_vld_d = 1'b0;
                run_d      = 4'd0;
                // prev_vld=0 already marks the invalid state, so only the
                // entry edge raises; reset counts as already being invalid
                if (prev_vld_q)
                    raise = 2'b01;
            end
        end

        if (raise != 2'b00) begin
            err_d = 1'b1;
            // keep the first error unless a clear arrives in the same cycle
            if (!err_q || mon.clr_err)
                code_d = raise;
        end else if (mon.clr_err) begin
            err_d  = 1'b0;
            code_d = 2'b00;
        end

        locked_d = (run_d >= LOCK_TH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 8'h00;
            s2_q       <= 8'h00;
            prev_vld_q <= 1'b0;
            step_q     <= 3'd0;
            vld_q      <= 1'b0;
            dir_q      <= 1'b1;
            run_q      <= 4'd0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'b00;
            cnt_q      <= '0;
`ifdef GLITCH_FILTER_EN
            dec_prev_q <= 4'b0000;
`endif
        end else begin
            s1_q       <= mon.pat_in;
            s2_q       <= s1_q;
            prev_vld_q <= prev_vld_d;
            step_q     <= step_d;
            vld_q      <= vld_d;
            dir_q      <= dir_d;
            run_q      <= run_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
`ifdef GLITCH_FILTER_EN
            dec_prev_q <= dec;
`endif
        end
    end

    assign mon.step     = step_q;
    assign mon.step_vld = vld_q;
    assign mon.dir      = dir_q;
    assign mon.locked   = locked_q;
    assign mon.err      = err_q;
    assign mon.err_code = code_q;
    assign mon.step_cnt = cnt_q;
endmodule

// File: tb/tb_bit_ctrl_seq_monitor.sv
// tb/tb_bit_ctrl_seq_monitor.sv - scoreboard bench for bit_ctrl_seq_monitor
module tb_bit_ctrl_seq_monitor;
    localparam int LC = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bit_ctrl_seq_monitor_if #(.CNT_W(CW)) bus();

    bit_ctrl_seq_monitor #(.LOCK_COUNT(LC), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (bus)
    );

    typedef struct packed {
        logic [2:0]    step;
        logic          vld;
        logic          dir;
        logic          locked;
        logic          err;
        logic [1:0]    code;
        logic [CW-1:0] cnt;
    } exp_t;

    logic [7:0] pats [6] = '{8'h90, 8'h18, 8'h48, 8'h60, 8'h24, 8'h84};

    int n_total  = 0;
    int n_passed = 0;

    // reference model state
    int m_step, m_run, m_code, m_cnt, m_last;
    bit m_prev, m_vld, m_dir, m_err;
    logic [7:0] pipe[$];
    exp_t sbq[$];
    int cur;

    function automatic int pat_idx(input logic [7:0] p);
        for (int i = 0; i < 6; i++)
            if (pats[i] == p) return i;
        return -1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.step   = 3'(m_step);
        e.vld    = m_vld;
        e.dir    = m_dir;
        e.locked = (m_run >= LC);
        e.err    = m_err;
        e.code   = 2'(m_code);
        e.cnt    = CW'(m_cnt);
        return e;
    endfunction

    task automatic reset_model();
        m_step = 0; m_run = 0; m_code = 0; m_cnt = 0; m_last = -1;
        m_prev = 0; m_vld = 0; m_dir = 1; m_err = 0;
        pipe = '{8'h00, 8'h00};
        sbq.delete();
    endtask

    task automatic model_step(input logic [7:0] p, input bit clr);
        int i;
        int raise;
        bit acc;
        bit f;
        i = pat_idx(p);
        raise = 0;
        acc = 1;
`ifdef GLITCH_FILTER_EN
        acc = (i == m_last);
        m_last = i;
`endif
        if (acc) begin
            if (i >= 0) begin
                m_vld = 1;
                if (!m_prev) begin
                    m_prev = 1; m_step = i; m_run = 0;
                end else if (i == m_step) begin
                end else if (i == (m_step + 1) % 6 || i == (m_step + 5) % 6) begin
                    f = (i == (m_step + 1) % 6);
                    m_run = (m_dir == f) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
                    m_dir = f;
                    m_cnt = (m_cnt + 1) % (1 << CW);
                    m_step = i;
                end else begin
                    m_step = i; m_run = 0; raise = 2;
                end
            end else begin
                m_vld = 0;
                if (m_prev) raise = 1;
                m_prev = 0;
                m_run = 0;
            end
        end
        if (raise != 0) begin
            if (!m_err || clr) m_code = raise;
            m_err = 1;
        end else if (clr) begin
            m_err = 0;
            m_code = 0;
        end
    endtask

    // drive one cycle of stimulus (caller is at a negedge) and queue the
    // expected outputs after the next rising edge
    task automatic drive(input logic [7:0] p, input bit clr);
        bus.pat_in  = p;
        bus.clr_err = clr;
        pipe.push_back(p);
        model_step(pipe.pop_front(), clr);
        sbq.push_back(model_out());
    endtask

    task automatic cycle(input logic [7:0] p, input bit clr);
        @(negedge clk);
        drive(p, clr);
    endtask

    task automatic hold(input logic [7:0] p, input int n);
        for (int k = 0; k < n; k++) cycle(p, 1'b0);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_reset_vals(input string name);
        exp_t a, e;
        a = {bus.step, bus.step_vld, bus.dir, bus.locked, bus.err, bus.err_code, bus.step_cnt};
        e = '{step: 3'd0, vld: 1'b0, dir: 1'b1, locked: 1'b0, err: 1'b0, code: 2'b00, cnt: '0};
        check(name, int'(a), int'(e));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_immediate");
        reset_model();
        repeat (2) @(negedge clk);
        check_reset_vals("reset_held");
        rst_n = 1'b1;
        drive(bus.pat_in, 1'b0);
    endtask

    // monitor: compare DUT outputs with the oldest expectation each cycle
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = {bus.step, bus.step_vld, bus.dir, bus.locked, bus.err, bus.err_code, bus.step_cnt};
                n_total++;
                if (a === e) n_passed++;
                else $display("FAIL scoreboard t=%0t got step=%0d vld=%0b dir=%0b lock=%0b err=%0b code=%0d cnt=%0d expected step=%0d vld=%0b dir=%0b lock=%0b err=%0b code=%0d cnt=%0d",
                              $time, a.step, a.vld, a.dir, a.locked, a.err, a.code, a.cnt,
                              e.step, e.vld, e.dir, e.locked, e.err, e.code, e.cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;
        int r;
        rst_n       = 1'b0;
        bus.pat_in  = 8'h00;
        bus.clr_err = 1'b0;
        reset_model();
        do_reset();

        // forward run with wrap 5->0
        for (int i = 0; i < 7; i++) hold(pats[i % 6], 4);
        check("fwd_step", int'(bus.step), 0);
        check("fwd_cnt", int'(bus.step_cnt), 6);
        check("fwd_locked", int'(bus.locked), 1);
        check("fwd_err", int'(bus.err), 0);

        // reverse after lock, wrap 0->5
        hold(8'h84, 4);
        check("rev_dir", int'(bus.dir), 0);
        check("rev_locked", int'(bus.locked), 0);
        hold(8'h24, 4);
        hold(8'h60, 4);
        check("rev_step", int'(bus.step), 3);
        check("rev_cnt", int'(bus.step_cnt), 9);

        // walk back to step 0, then skip to step 3
        hold(8'h48, 4); hold(8'h18, 4); hold(8'h90, 4);
        cnt0 = int'(bus.step_cnt);
        hold(8'h60, 4);
        check("skip_err", int'(bus.err), 1);
        check("skip_code", int'(bus.err_code), 2);
        check("skip_step", int'(bus.step), 3);
        check("skip_cnt", int'(bus.step_cnt), cnt0);
        hold(8'h24, 4);

        // clear, invalid, then skip keeps the first code
        cycle(8'h24, 1'b1);
        hold(8'h24, 3);
        check("clr_err", int'(bus.err), 0);
        hold(8'h00, 4);
        check("inv_vld", int'(bus.step_vld), 0);
        check("inv_code", int'(bus.err_code), 1);
        hold(8'h90, 4);
        hold(8'h60, 4);
        check("first_err_kept", int'(bus.err_code), 1);
        // clear coinciding with a new skip: new error wins
        cycle(8'h90, 1'b0);
        cycle(8'h90, 1'b0);
`ifdef GLITCH_FILTER_EN
        cycle(8'h90, 1'b0);
`endif
        cycle(8'h90, 1'b1);
        hold(8'h90, 4);
        check("clr_vs_new_err", int'(bus.err), 1);
        check("clr_vs_new_code", int'(bus.err_code), 2);
        cycle(8'h90, 1'b1);

        // lock at step 4, then reset mid-operation
        hold(8'h18, 3); hold(8'h48, 3); hold(8'h60, 3); hold(8'h24, 4);
        check("pre_reset_locked", int'(bus.locked), 1);
        do_reset();
        hold(8'h24, 4);
        check("reacq_step", int'(bus.step), 4);
        check("reacq_cnt", int'(bus.step_cnt), 0);
        check("reacq_err", int'(bus.err), 0);

        // single-cycle glitch
        hold(8'h90, 4);
        cnt0 = int'(bus.step_cnt);
        cycle(8'h18, 1'b0);
        hold(8'h90, 4);
`ifdef GLITCH_FILTER_EN
        check("glitch_cnt", int'(bus.step_cnt), cnt0);
`else
        check("glitch_cnt", int'(bus.step_cnt), (cnt0 + 2) % (1 << CW));
`endif

        // randomized walk
        cur = 0;
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15)      cur = (cur + 1) % 6;
            else if (r < 30) cur = (cur + 5) % 6;
            else if (r < 34) cur = (cur + int'($urandom_range(2, 4))) % 6;
            if (r >= 34 && r < 37)
                cycle(8'($urandom_range(0, 255)), ($urandom_range(0, 19) == 0));
            else
                cycle(pats[cur], ($urandom_range(0, 29) == 0));
        end
        hold(pats[cur], 4);

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        check("sb_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end
endmodule
